// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the request/grant handshake and bus status lines between the
// arbiter and the bus masters.
//   request             masters -> arbiter, per-master level request
//   grant               arbiter -> masters, one-hot single-cycle grant pulse
//   begin_transactionIN masters -> arbiter, OR of all begin_transaction
//   end_transactionIN   bus     -> arbiter, OR of end_transaction
//   errorIN             slaves  -> arbiter, bus error
//   timeout_errorOUT    arbiter -> bus, one-cycle arbiter-generated error
//   active_master       arbiter -> bus, index of current owner
//   bus_busy            arbiter -> bus, ownership in progress
// Modport master is the arbiter's view, modport slave the requesters' view.
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] grant;
  logic                   begin_transactionIN;
  logic                   end_transactionIN;
  logic                   errorIN;
  logic                   timeout_errorOUT;
  logic [2:0]             active_master;
  logic                   bus_busy;

  modport master (
    input  request,
    input  begin_transactionIN,
    input  end_transactionIN,
    input  errorIN,
    output grant,
    output timeout_errorOUT,
    output active_master,
    output bus_busy
  );

  modport slave (
    output request,
    output begin_transactionIN,
    output end_transactionIN,
    output errorIN,
    input  grant,
    input  timeout_errorOUT,
    input  active_master,
    input  bus_busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin bus arbiter with begin and transfer watchdogs.
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high
//   bus    bus_arbiter_if.master: request in, grant out, begin/end/error in,
//          timeout_errorOUT, active_master, bus_busy out
// All outputs are registers updated by the FSM; request only reaches grant
// through the owner/grant registers.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int XFER_TIMEOUT  = 256
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  localparam int                    CNT_W      = $clog2(XFER_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      BEGIN_LAST = CNT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [2:0]            LAST_IDX   = 3'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GRANT       = 3'd1,
    WAIT_BEGIN  = 3'd2,
    ACTIVE      = 3'd3,
    TIMEOUT_ERR = 3'd4
  } state_t;

  state_t                 state_r;
  logic [2:0]             owner_r;
  logic [2:0]             last_owner_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic                   timeout_error_r;
  logic [2:0]             active_master_r;
  logic                   bus_busy_r;
  logic [2:0]             winner_s;

  // Saturating increment: the watchdog counter must never wrap to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Round-robin pick: scan downward from the farthest offset so the nearest
  // requester after last_owner is the last (winning) assignment.
  always_comb begin
    winner_s = 3'd0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      winner_s = bus.request[(int'(last_owner_r) + off) % NUM_MASTERS]
                 ? 3'((int'(last_owner_r) + off) % NUM_MASTERS)
                 : winner_s;
    end
  end

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= IDLE;
      owner_r         <= 3'd0;
      last_owner_r    <= LAST_IDX;
      cnt_r           <= {CNT_W{1'b0}};
      grant_r         <= {NUM_MASTERS{1'b0}};
      timeout_error_r <= 1'b0;
      active_master_r <= 3'd0;
      bus_busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_error_r <= 1'b0;
          cnt_r           <= {CNT_W{1'b0}};
          if (|bus.request) begin
            state_r         <= GRANT;
            owner_r         <= winner_s;
            grant_r         <= GRANT_ONE << winner_s;
            active_master_r <= winner_s;
            bus_busy_r      <= 1'b1;
          end else begin
            grant_r    <= {NUM_MASTERS{1'b0}};
            bus_busy_r <= 1'b0;
          end
        end

        GRANT: begin
          grant_r <= {NUM_MASTERS{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
          if (bus.errorIN) begin
            state_r         <= IDLE;
            last_owner_r    <= owner_r;
            active_master_r <= owner_r;
            bus_busy_r      <= 1'b0;
          end else begin
            state_r <= WAIT_BEGIN;
          end
        end

        WAIT_BEGIN: begin
          grant_r <= {NUM_MASTERS{1'b0}};
          // Error, a zero-length transfer (begin+end together) and the begin
          // watchdog all release ownership without raising timeout_errorOUT.
          if (bus.errorIN || (bus.begin_transactionIN && bus.end_transactionIN)
              || (!bus.begin_transactionIN && cnt_r >= BEGIN_LAST)) begin
            state_r         <= IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            last_owner_r    <= owner_r;
            active_master_r <= owner_r;
            bus_busy_r      <= 1'b0;
          end else if (bus.begin_transactionIN) begin
            state_r <= ACTIVE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_inc(cnt_r);
          end
        end

        ACTIVE: begin
          grant_r <= {NUM_MASTERS{1'b0}};
          if (bus.errorIN || bus.end_transactionIN) begin
            state_r         <= IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            last_owner_r    <= owner_r;
            active_master_r <= owner_r;
            bus_busy_r      <= 1'b0;
          end else if (cnt_r >= XFER_LAST) begin
            state_r         <= TIMEOUT_ERR;
            cnt_r           <= {CNT_W{1'b0}};
            timeout_error_r <= 1'b1;
          end else begin
            cnt_r <= cnt_inc(cnt_r);
          end
        end

        TIMEOUT_ERR: begin
          state_r         <= IDLE;
          cnt_r           <= {CNT_W{1'b0}};
          grant_r         <= {NUM_MASTERS{1'b0}};
          timeout_error_r <= 1'b0;
          last_owner_r    <= owner_r;
          active_master_r <= owner_r;
          bus_busy_r      <= 1'b0;
        end

        default: begin
          state_r         <= IDLE;
          cnt_r           <= {CNT_W{1'b0}};
          grant_r         <= {NUM_MASTERS{1'b0}};
          timeout_error_r <= 1'b0;
          bus_busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant            = grant_r;
  assign bus.timeout_errorOUT = timeout_error_r;
  assign bus.active_master    = active_master_r;
  assign bus.bus_busy         = bus_busy_r;

endmodule
